load_store_unit: RTL and testbench

Memory-access stage placed directly downstream of the core's EXECUTE state. It takes a decoded load or store (byte address already computed as rs1+imm, funct3, rs2 data) and runs one transaction against the 32-bit word memory over a valid/ready handshake. For stores it steers byte and halfword lanes. For loads it returns a sign- or zero-extended result for register write-back. Misaligned and illegal accesses are rejected without touching memory.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/lsu_align.sv | 87 ++++++++
 rtl/load_store_unit.sv | 145 ++++++++++++++
 tb/tb_load_store_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the core and its memory-access stage.
// Holds the funct3 access-size encodings, the major opcodes used by the
// decoder, and the state encoding of the load/store unit.
package cpu_pkg;

    // funct3 access size / signedness for loads and stores
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Major opcodes recognised by the decoder
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    // Load/store unit states
    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_DONE = 2'd2
    } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering and legality check for the load/store unit.
// Ports:
//   addr_lo    in   low two bits of the byte address
//   funct3     in   access size/sign
//   is_load    in   access is a load (otherwise a store)
//   wdata      in   raw store data (rs2)
//   mem_rdata  in   word returned by memory
//   mem_wdata  out  store data replicated across the lanes
//   mem_wmask  out  byte enables for the store
//   load_data  out  extracted and extended load value
//   misaligned out  access not naturally aligned
//   illegal    out  funct3 not legal for the access type
module lsu_align
    import cpu_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic        is_load,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    output logic [31:0] load_data,
    output logic        misaligned,
    output logic        illegal
);

    logic [31:0] shifted;

    assign shifted = mem_rdata >> {addr_lo, 3'b000};

    // Legality first; alignment is only reported for legal accesses so the
    // two flags are never set together.
    always_comb begin
        illegal    = 1'b1;
        misaligned = 1'b0;
        case (funct3)
            F3_B, F3_H, F3_W: illegal = 1'b0;
            F3_BU, F3_HU:     illegal = !is_load;
            default:          illegal = 1'b1;
        endcase
        if (!illegal) begin
            case (funct3[1:0])
                2'b01:   misaligned = addr_lo[0];
                2'b10:   misaligned = |addr_lo;
                default: misaligned = 1'b0;
            endcase
        end
    end

    // Store lane replication and byte enables
    always_comb begin
        mem_wdata = 32'h0;
        mem_wmask = 4'b0000;
        case (funct3)
            F3_B: begin
                mem_wdata = {4{wdata[7:0]}};
                mem_wmask = 4'b0001 << addr_lo;
            end
            F3_H: begin
                mem_wdata = {2{wdata[15:0]}};
                mem_wmask = addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            F3_W: begin
                mem_wdata = wdata;
                mem_wmask = 4'b1111;
            end
            default: begin
                mem_wdata = 32'h0;
                mem_wmask = 4'b0000;
            end
        endcase
    end

    // Load extraction from the lane-shifted word
    always_comb begin
        load_data = shifted;
        case (funct3)
            F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   load_data = {24'h0, shifted[7:0]};
            F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   load_data = {16'h0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: runs one load or store per request against a
// 32-bit word memory over a valid/ready handshake.
// Ports:
//   clk, resetn                     clock, async active-low reset
//   start, is_load, is_store        request pulse and access type
//   funct3, addr, wdata             access size, byte address, store data
//   busy, done                      not idle / one-cycle completion pulse
//   rdata                           extended load result
//   misaligned, illegal             rejection flags, valid with done
//   mem_addr, mem_wdata, mem_wmask  word address, store data, byte enables
//   mem_rstrb, mem_valid            read strobe, transaction request
//   mem_ready, mem_rdata            memory accept / returned word
module load_store_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              is_load,
    input  logic              is_store,
    input  logic [2:0]        funct3,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              misaligned,
    output logic              illegal,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wmask,
    output logic              mem_rstrb,
    output logic              mem_valid,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata
);

    lsu_state_t state, next_state;

    logic [ADDR_W+1:0] addr_q;
    logic [2:0]        funct3_q;
    logic [31:0]       wdata_q;
    logic              load_q;

    logic        idle;
    logic        accept;
    logic [1:0]  al_addr_lo;
    logic [2:0]  al_funct3;
    logic        al_is_load;
    logic [31:0] al_wdata;
    logic [31:0] al_mem_wdata;
    logic [3:0]  al_mem_wmask;
    logic [31:0] al_load_data;
    logic        al_misaligned;
    logic        al_illegal;
    logic        unused_addr_hi;

    assign unused_addr_hi = ^addr[31:ADDR_W+2];

    assign idle   = (state == LSU_IDLE);
    assign accept = idle & start & (is_load ^ is_store);

    // While idle the aligner judges the incoming request so a rejection can
    // complete straight away; afterwards it works from the captured request,
    // which keeps every mem_* output stable for the whole transaction.
    assign al_addr_lo = idle ? addr[1:0] : addr_q[1:0];
    assign al_funct3  = idle ? funct3    : funct3_q;
    assign al_is_load = idle ? is_load   : load_q;
    assign al_wdata   = idle ? wdata     : wdata_q;

    lsu_align u_align (
        .addr_lo    (al_addr_lo),
        .funct3     (al_funct3),
        .is_load    (al_is_load),
        .wdata      (al_wdata),
        .mem_rdata  (mem_rdata),
        .mem_wdata  (al_mem_wdata),
        .mem_wmask  (al_mem_wmask),
        .load_data  (al_load_data),
        .misaligned (al_misaligned),
        .illegal    (al_illegal)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= LSU_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            LSU_IDLE: begin
                if (accept) begin
                    next_state = (al_misaligned | al_illegal) ? LSU_DONE : LSU_REQ;
                end
            end
            LSU_REQ: begin
                if (mem_ready) begin
                    next_state = LSU_DONE;
                end
            end
            LSU_DONE: next_state = LSU_IDLE;
            default:  next_state = LSU_IDLE;
        endcase
    end

    // Request capture, rejection flags and the load result register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_q     <= '0;
            funct3_q   <= 3'b000;
            wdata_q    <= 32'h0;
            load_q     <= 1'b0;
            misaligned <= 1'b0;
            illegal    <= 1'b0;
            rdata      <= 32'h0;
        end else begin
            if (accept) begin
                addr_q     <= addr[ADDR_W+1:0];
                funct3_q   <= funct3;
                wdata_q    <= wdata;
                load_q     <= is_load;
                misaligned <= al_misaligned;
                illegal    <= al_illegal;
            end
            if ((state == LSU_REQ) && mem_ready && load_q) begin
                rdata <= al_load_data;
            end
        end
    end

    assign busy      = !idle;
    assign done      = (state == LSU_DONE);
    assign mem_valid = (state == LSU_REQ);
    assign mem_rstrb = mem_valid & load_q;
    assign mem_addr  = addr_q[ADDR_W+1:2];
    assign mem_wdata = mem_valid ? al_mem_wdata : 32'h0;
    assign mem_wmask = (mem_valid && !load_q) ? al_mem_wmask : 4'b0000;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed accesses push their
// expected completion into a scoreboard; a monitor pops and compares on done.
module tb_load_store_unit;

    localparam int ADDR_W = 12;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              start = 1'b0;
    logic              is_load = 1'b0;
    logic              is_store = 1'b0;
    logic [2:0]        funct3 = 3'b000;
    logic [31:0]       addr = 32'h0;
    logic [31:0]       wdata = 32'h0;
    logic              busy;
    logic              done;
    logic [31:0]       rdata;
    logic              misaligned;
    logic              illegal;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wmask;
    logic              mem_rstrb;
    logic              mem_valid;
    logic              mem_ready = 1'b0;
    logic [31:0]       mem_rdata = 32'h0;

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        logic        ill;
        string       name;
    } exp_t;

    exp_t sb[$];

    load_store_unit #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .is_load    (is_load),
        .is_store   (is_store),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .busy       (busy),
        .done       (done),
        .rdata      (rdata),
        .misaligned (misaligned),
        .illegal    (illegal),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wmask  (mem_wmask),
        .mem_rstrb  (mem_rstrb),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every done must match the oldest expectation
    always @(negedge clk) begin
        if (resetn && done === 1'b1) begin
            if (sb.size() == 0) begin
                checkOutput("spurious_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput({e.name, "_rdata"}, rdata, e.rdata);
                checkOutput({e.name, "_flags"}, {30'b0, misaligned, illegal}, {30'b0, e.mis, e.ill});
            end
        end
    end

    // One access; k counts negedges after the edge that sampled start, so
    // done seen at k means done at edge k.
    task automatic applyStimulus(
        input string name, input logic ld, input logic st, input logic [2:0] f3,
        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
        input int ready_wait, input int exp_lat, input logic [31:0] exp_rdata,
        input logic exp_mis, input logic exp_ill, input logic [31:0] exp_maddr,
        input logic [31:0] exp_mwdata, input logic [3:0] exp_mask,
        input bit busy_poke, input bit done_poke);
        int k;
        exp_t e;
        @(negedge clk);
        mem_rdata = rd;
        start = 1'b1; is_load = ld; is_store = st; funct3 = f3; addr = a; wdata = wd;
        e.rdata = exp_rdata; e.mis = exp_mis; e.ill = exp_ill; e.name = name;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        k = 1;
        mem_ready = (k > ready_wait);
        if (exp_lat == 1) begin
            checkOutput({name, "_novalid"}, {31'b0, mem_valid}, 32'd0);
        end
        while (done !== 1'b1 && k < 30) begin
            checkOutput({name, "_valid"}, {31'b0, mem_valid}, 32'd1);
            checkOutput({name, "_busy"}, {31'b0, busy}, 32'd1);
            checkOutput({name, "_maddr"}, 32'(mem_addr), exp_maddr);
            checkOutput({name, "_rstrb"}, {31'b0, mem_rstrb}, {31'b0, ld});
            checkOutput({name, "_wmask"}, {28'b0, mem_wmask}, {28'b0, (st ? exp_mask : 4'b0000)});
            if (st) begin
                checkOutput({name, "_wdata"}, mem_wdata, exp_mwdata);
            end
            if (busy_poke && k == 2) begin
                start = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h40;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            k++;
            mem_ready = (k > ready_wait);
        end
        start = 1'b0;
        checkOutput({name, "_latency"}, k, exp_lat);
        mem_ready = 1'b0;
        if (done_poke) begin
            start = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h0;
            @(negedge clk);
            start = 1'b0;
            checkOutput({name, "_donepoke_idle"}, {31'b0, busy}, 32'd0);
        end
    endtask

    initial begin
        #20000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (2) @(negedge clk);
        checkOutput("reset_ctrl", {24'b0, busy, done, misaligned, illegal, mem_valid, mem_rstrb, 2'b0}, 32'd0);
        checkOutput("reset_mask", {28'b0, mem_wmask}, 32'd0);
        checkOutput("reset_rdata", rdata, 32'd0);
        checkOutput("reset_mwdata", mem_wdata, 32'd0);
        checkOutput("reset_maddr", 32'(mem_addr), 32'd0);
        resetn = 1'b1;

        //             name    ld    st    f3      addr   wdata         mem_rdata     rw lat rdata        mis   ill   maddr wdata_exp     mask
        applyStimulus("sb",  1'b0, 1'b1, 3'b000, 32'h6, 32'h123456AB, 32'h0,        0, 2, 32'h0,        1'b0, 1'b0, 32'd1, 32'hABABABAB, 4'b0100, 0, 0);
        applyStimulus("sh",  1'b0, 1'b1, 3'b001, 32'h2, 32'h1234ABCD, 32'h0,        0, 2, 32'h0,        1'b0, 1'b0, 32'd0, 32'hABCDABCD, 4'b1100, 0, 0);
        applyStimulus("lb",  1'b1, 1'b0, 3'b000, 32'h7, 32'h0,        32'h80FF1234, 0, 2, 32'hFFFFFF80, 1'b0, 1'b0, 32'd1, 32'h0,        4'b0000, 0, 0);
        applyStimulus("lbu", 1'b1, 1'b0, 3'b100, 32'h7, 32'h0,        32'h80FF1234, 0, 2, 32'h00000080, 1'b0, 1'b0, 32'd1, 32'h0,        4'b0000, 0, 1);
        applyStimulus("lh",  1'b1, 1'b0, 3'b001, 32'h2, 32'h0,        32'h80015555, 0, 2, 32'hFFFF8001, 1'b0, 1'b0, 32'd0, 32'h0,        4'b0000, 0, 0);
        applyStimulus("lhu", 1'b1, 1'b0, 3'b101, 32'h2, 32'h0,        32'h80015555, 0, 2, 32'h00008001, 1'b0, 1'b0, 32'd0, 32'h0,        4'b0000, 0, 0);
        applyStimulus("lw_mis", 1'b1, 1'b0, 3'b010, 32'h6, 32'h0,     32'h11111111, 0, 1, 32'h00008001, 1'b1, 1'b0, 32'd0, 32'h0,        4'b0000, 0, 0);
        applyStimulus("sw_ill", 1'b0, 1'b1, 3'b100, 32'h0, 32'h5,     32'h0,        0, 1, 32'h00008001, 1'b0, 1'b1, 32'd0, 32'h0,        4'b0000, 0, 0);
        applyStimulus("ld_ill", 1'b1, 1'b0, 3'b011, 32'h1, 32'h0,     32'h22222222, 0, 1, 32'h00008001, 1'b0, 1'b1, 32'd0, 32'h0,        4'b0000, 0, 0);

        // Both type bits set: start must be ignored
        @(negedge clk);
        start = 1'b1; is_load = 1'b1; is_store = 1'b1; funct3 = 3'b010; addr = 32'h0;
        @(negedge clk);
        start = 1'b0; is_store = 1'b0;
        checkOutput("both_set_ignored", {31'b0, busy}, 32'd0);
        @(negedge clk);

        applyStimulus("sw_wait", 1'b0, 1'b1, 3'b010, 32'h10, 32'hCAFEF00D, 32'h0,   3, 5, 32'h00008001, 1'b0, 1'b0, 32'd4, 32'hCAFEF00D, 4'b1111, 1, 0);

        // Reset while a load is waiting in REQ
        @(negedge clk);
        start = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h20;
        mem_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        checkOutput("pre_reset_valid", {31'b0, mem_valid}, 32'd1);
        @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        checkOutput("async_reset_ctrl", {29'b0, mem_valid, busy, done}, 32'd0);
        checkOutput("async_reset_rdata", rdata, 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        applyStimulus("lw_after_reset", 1'b1, 1'b0, 3'b010, 32'h0, 32'h0, 32'hDEADBEEF, 0, 2, 32'hDEADBEEF, 1'b0, 1'b0, 32'd0, 32'h0, 4'b0000, 0, 0);

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
